mton_sync_fifo: RTL and testbench

Single-clock M-writer / N-reader FIFO with element-granular storage. Each cycle it accepts up to M_WRITERS pushes and serves up to N_READERS pops, packing accepted pushes contiguously in lane order. Read data is first-word-fall-through (FWFT). The block is the same-clock-domain successor to the M:N async FIFO. It is used where producers and consumers share one clock and need multiple transfers per cycle without packet-granular pops.

---
 rtl/mton_fifo_pkg.sv | 17 +
 rtl/mton_sync_fifo_if.sv | 36 +++
 rtl/mton_prefix_grant.sv | 26 ++
 rtl/mton_sync_fifo.sv | 114 +++++++++++
 tb/tb_mton_sync_fifo.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mton_fifo_pkg.sv
// rtl/mton_fifo_pkg.sv - shared rank type and popcount helper for the M:N sync FIFO
package mton_fifo_pkg;

  // Widest lane count of any instance; must be >= max(M_WRITERS, N_READERS)
  localparam int MAX_LANES = 2;

  // Holds a lane rank and a grant popcount (0 .. MAX_LANES)
  typedef logic [$clog2(MAX_LANES):0] rank_t;

  function automatic rank_t popcount(input logic [MAX_LANES-1:0] v);
    rank_t n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + rank_t'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mton_sync_fifo_if.sv
// rtl/mton_sync_fifo_if.sv - writer/reader lane bundle of the M:N sync FIFO
interface mton_sync_fifo_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int M_WRITERS = 2,
  parameter int N_READERS = 2
);
  logic [M_WRITERS-1:0]       i_wr_en;
  logic [M_WRITERS*WIDTH-1:0] i_wr_data;
  logic [M_WRITERS-1:0]       o_wr_ed;
  logic                       o_wr_full;
  logic                       o_wr_afull;
  logic                       o_wr_pfull;
  logic [DEPTH:0]             o_wr_remain;
  logic [N_READERS-1:0]       i_rd_en;
  logic [N_READERS-1:0]       o_rd_ed;
  logic [N_READERS*WIDTH-1:0] o_rd_data;
  logic                       o_rd_empty;
  logic                       o_rd_aempty;
  logic                       o_rd_pempty;
  logic [DEPTH:0]             o_rd_depth;

  // Producers/consumers side
  modport master (
    output i_wr_en, i_wr_data, i_rd_en,
    input  o_wr_ed, o_wr_full, o_wr_afull, o_wr_pfull, o_wr_remain,
    input  o_rd_ed, o_rd_data, o_rd_empty, o_rd_aempty, o_rd_pempty, o_rd_depth
  );

  // FIFO side
  modport slave (
    input  i_wr_en, i_wr_data, i_rd_en,
    output o_wr_ed, o_wr_full, o_wr_afull, o_wr_pfull, o_wr_remain,
    output o_rd_ed, o_rd_data, o_rd_empty, o_rd_aempty, o_rd_pempty, o_rd_depth
  );
endinterface

// File: rtl/mton_prefix_grant.sv
// rtl/mton_prefix_grant.sv - per-lane prefix rank and grant against an availability count
module mton_prefix_grant
  import mton_fifo_pkg::*;
#(
  parameter int LANES = 2,
  parameter int AW    = 5
) (
  input  logic [LANES-1:0] req,
  input  logic [AW-1:0]    avail,
  output rank_t            rank [LANES],
  output logic [LANES-1:0] grant
);

  // Rank = requests below this lane; grant while the rank still fits in avail
  always_comb begin
    rank_t acc;
    acc   = '0;
    grant = '0;
    for (int k = 0; k < LANES; k++) begin
      rank[k]  = acc;
      grant[k] = req[k] && (AW'(acc) < avail);
      acc      = acc + rank_t'(req[k]);
    end
  end

endmodule

// File: rtl/mton_sync_fifo.sv
// rtl/mton_sync_fifo.sv - single-clock M-writer/N-reader FWFT FIFO; MTON_SYNC_FIFO_STATS_EN adds drop/miss counters
module mton_sync_fifo
  import mton_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int PFULL_TH  = 4,
  parameter int PEMPTY_TH = 4,
  parameter int M_WRITERS = 2,
  parameter int N_READERS = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  mton_sync_fifo_if.slave    bus
`ifdef MTON_SYNC_FIFO_STATS_EN
  ,
  output logic [15:0]        o_wr_drop_cnt,
  output logic [15:0]        o_rd_miss_cnt
`endif
);

  localparam int CAP = 2 ** DEPTH;

  logic [WIDTH-1:0]     mem [CAP];
  logic [DEPTH-1:0]     wptr;
  logic [DEPTH-1:0]     rptr;
  logic [DEPTH:0]       count;
  logic [DEPTH:0]       free;
  rank_t                wr_rank [M_WRITERS];
  rank_t                rd_rank [N_READERS];
  logic [M_WRITERS-1:0] wr_grant;
  logic [N_READERS-1:0] rd_grant;
  rank_t                nw;
  rank_t                nr;

  // Space freed by a pop this cycle is not offered to pushes until the next one
  assign free = (DEPTH + 1)'(CAP) - count;

  mton_prefix_grant #(.LANES(M_WRITERS), .AW(DEPTH + 1)) u_wr_grant (
    .req   (bus.i_wr_en),
    .avail (free),
    .rank  (wr_rank),
    .grant (wr_grant)
  );

  mton_prefix_grant #(.LANES(N_READERS), .AW(DEPTH + 1)) u_rd_grant (
    .req   (bus.i_rd_en),
    .avail (count),
    .rank  (rd_rank),
    .grant (rd_grant)
  );

  assign nw = popcount(wr_grant);
  assign nr = popcount(rd_grant);

  assign bus.o_wr_ed     = wr_grant;
  assign bus.o_rd_ed     = rd_grant;
  assign bus.o_wr_remain = free;
  assign bus.o_rd_depth  = count;
  assign bus.o_wr_full   = (count == (DEPTH + 1)'(CAP));
  assign bus.o_wr_afull  = (free <= (DEPTH + 1)'(1));
  assign bus.o_wr_pfull  = (free <= (DEPTH + 1)'(PFULL_TH));
  assign bus.o_rd_empty  = (count == '0);
  assign bus.o_rd_aempty = (count <= (DEPTH + 1)'(1));
  assign bus.o_rd_pempty = (count <= (DEPTH + 1)'(PEMPTY_TH));

  // Granted writers pack contiguously from wptr; storage has no reset
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < M_WRITERS; k++) begin
      if (wr_grant[k]) mem[wptr + DEPTH'(wr_rank[k])] <= bus.i_wr_data[k*WIDTH +: WIDTH];
    end
  end

  // Granted readers see consecutive elements from rptr; idle lanes drive zero
  always_comb begin
    bus.o_rd_data = '0;
    for (int r = 0; r < N_READERS; r++) begin
      if (rd_grant[r]) bus.o_rd_data[r*WIDTH +: WIDTH] = mem[rptr + DEPTH'(rd_rank[r])];
    end
  end

  // Pointer and occupancy update from the grant popcounts
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + DEPTH'(nw);
      rptr  <= rptr + DEPTH'(nr);
      count <= count + (DEPTH + 1)'(nw) - (DEPTH + 1)'(nr);
    end
  end

`ifdef MTON_SYNC_FIFO_STATS_EN
  logic [16:0] drop_sum;
  logic [16:0] miss_sum;

  assign drop_sum = {1'b0, o_wr_drop_cnt} + 17'(popcount(bus.i_wr_en & ~wr_grant));
  assign miss_sum = {1'b0, o_rd_miss_cnt} + 17'(popcount(bus.i_rd_en & ~rd_grant));

  // Saturating counts of refused push and pop requests
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_wr_drop_cnt <= '0;
      o_rd_miss_cnt <= '0;
    end else begin
      o_wr_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      o_rd_miss_cnt <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_mton_sync_fifo.sv
// tb/tb_mton_sync_fifo.sv - self-checking bench for mton_sync_fifo against a queue model
module tb_mton_sync_fifo;

  localparam int CAP = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] q[$];
  int   exp_drop = 0;
  int   exp_miss = 0;

  mton_sync_fifo_if #(.WIDTH(8), .DEPTH(4), .M_WRITERS(2), .N_READERS(2)) ifc ();

`ifdef MTON_SYNC_FIFO_STATS_EN
  logic [15:0] wr_drop_cnt;
  logic [15:0] rd_miss_cnt;
`endif

  mton_sync_fifo #(
    .WIDTH(8), .DEPTH(4), .PFULL_TH(4), .PEMPTY_TH(4), .M_WRITERS(2), .N_READERS(2)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rst_n),
    .bus    (ifc)
`ifdef MTON_SYNC_FIFO_STATS_EN
    ,
    .o_wr_drop_cnt (wr_drop_cnt),
    .o_rd_miss_cnt (rd_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags();
    int n;
    n = q.size();
    chk("rd_empty", 32'(ifc.o_rd_empty), 32'(n == 0));
    chk("rd_aempty", 32'(ifc.o_rd_aempty), 32'(n <= 1));
    chk("rd_pempty", 32'(ifc.o_rd_pempty), 32'(n <= 4));
    chk("wr_full", 32'(ifc.o_wr_full), 32'(n == CAP));
    chk("wr_afull", 32'(ifc.o_wr_afull), 32'(CAP - n <= 1));
    chk("wr_pfull", 32'(ifc.o_wr_pfull), 32'(CAP - n <= 4));
    chk("wr_remain", 32'(ifc.o_wr_remain), 32'(CAP - n));
    chk("rd_depth", 32'(ifc.o_rd_depth), 32'(n));
  endtask

  // One clock cycle: drive, check against the model before the edge, then commit the model
  task automatic step(input logic [1:0] we, input logic [15:0] wd, input logic [1:0] re);
    int free, acc, srv;
    logic [1:0]  exp_wed, exp_red;
    logic [15:0] exp_rd;
    logic [7:0]  newq[$];
    ifc.i_wr_en = we;
    ifc.i_wr_data = wd;
    ifc.i_rd_en = re;
    @(negedge clk);
    free = CAP - q.size();
    acc = 0;
    srv = 0;
    exp_wed = '0;
    exp_red = '0;
    exp_rd = '0;
    for (int k = 0; k < 2; k++) begin
      if (we[k] && acc < free) begin
        exp_wed[k] = 1'b1;
        newq.push_back(wd[k*8 +: 8]);
        acc++;
      end else if (we[k]) exp_drop++;
    end
    for (int r = 0; r < 2; r++) begin
      if (re[r] && srv < q.size()) begin
        exp_red[r] = 1'b1;
        exp_rd[r*8 +: 8] = q[srv];
        srv++;
      end else if (re[r]) exp_miss++;
    end
    chk("wr_ed", 32'(ifc.o_wr_ed), 32'(exp_wed));
    chk("rd_ed", 32'(ifc.o_rd_ed), 32'(exp_red));
    chk("rd_data", 32'(ifc.o_rd_data), 32'(exp_rd));
    check_flags();
    @(posedge clk);
    repeat (srv) void'(q.pop_front());
    foreach (newq[i]) q.push_back(newq[i]);
    #1;
  endtask

  initial begin
    ifc.i_wr_en = '0;
    ifc.i_wr_data = '0;
    ifc.i_rd_en = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, with both readers requesting
    ifc.i_rd_en = 2'b11;
    #1;
    chk("rst_rd_ed", 32'(ifc.o_rd_ed), 32'h0);
    chk("rst_remain", 32'(ifc.o_wr_remain), 32'd16);
    chk("rst_pfull", 32'(ifc.o_wr_pfull), 32'h0);
    check_flags();
    @(posedge clk);
    #1;

    // Fill with both writers, then one refused burst
    for (int i = 0; i < 8; i++) step(2'b11, 16'(($urandom & 16'hFFFF)), 2'b00);
    chk("fill_depth", 32'(ifc.o_rd_depth), 32'd16);
    chk("fill_full", 32'(ifc.o_wr_full), 32'h1);
    step(2'b11, 16'hBEEF, 2'b00);

    // Count 15: only lane 0 fits
    step(2'b00, 16'h0, 2'b01);
    step(2'b11, 16'hA5C3, 2'b00);
    chk("partial_full", 32'(ifc.o_wr_full), 32'h1);

    // Full: pushes refused, both pops granted
    step(2'b11, 16'h1234, 2'b11);
    chk("full_pop_depth", 32'(ifc.o_rd_depth), 32'd14);

    // Drain, then lane-ordered pair
    for (int i = 0; i < 7; i++) step(2'b00, 16'h0, 2'b11);
    step(2'b11, 16'h2211, 2'b00);
    step(2'b00, 16'h0, 2'b11);
    chk("pair_depth", 32'(ifc.o_rd_depth), 32'd0);

    // Count 1: reader1 alone, then both readers
    step(2'b01, 16'h0033, 2'b00);
    step(2'b00, 16'h0, 2'b10);
    chk("r1_empty", 32'(ifc.o_rd_empty), 32'h1);
    step(2'b10, 16'h4400, 2'b00);
    step(2'b00, 16'h0, 2'b11);

    // Random traffic, write-heavy then read-heavy, crossing the array end repeatedly
    for (int i = 0; i < 300; i++) begin
      logic [1:0] re;
      re = (i < 150) ? ((($urandom % 3) == 0) ? 2'($urandom) : 2'b00) : 2'($urandom);
      step((i < 150 || ($urandom % 3) == 0) ? 2'($urandom) : 2'b00, 16'($urandom), re);
    end

    // Asynchronous reset mid-cycle discards everything
    step(2'b11, 16'h6655, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_depth", 32'(ifc.o_rd_depth), 32'h0);
    chk("arst_empty", 32'(ifc.o_rd_empty), 32'h1);
    exp_drop = 0;
    exp_miss = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b01, 16'h0077, 2'b11);
    step(2'b00, 16'h0, 2'b01);

`ifdef MTON_SYNC_FIFO_STATS_EN
    chk("drop_cnt", 32'(wr_drop_cnt), 32'(exp_drop));
    chk("miss_cnt", 32'(rd_miss_cnt), 32'(exp_miss));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
